// File: rtl/ysyx_23060203_axi_pkg.sv
// Shared AXI encodings and state type for the ysyx_23060203 SRAM responders.
package ysyx_23060203_axi_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } resp_e;

   localparam logic [2:0] SIZE_32 = 3'b010;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'b001,
      ST_WAIT  = 3'b010,
      ST_BURST = 3'b100
   } state_t;

   // A request this slave cannot serve shape-wise fails for every beat.
   function automatic logic burst_slverr(input logic [2:0] size, input burst_e burst,
                                         input logic [7:0] len);
      logic bad_wrap;
      bad_wrap = (burst == BURST_WRAP) &&
                 !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
      return (size != SIZE_32) || (burst == BURST_RSVD) || bad_wrap;
   endfunction

endpackage

// File: rtl/ysyx_23060203_axi_burst_addr.sv
// Next-beat address for FIXED/INCR/WRAP bursts of 32-bit beats.
module ysyx_23060203_axi_burst_addr
   import ysyx_23060203_axi_pkg::*;
(
   input  logic [31:0] addr,
   input  logic [7:0]  len,
   input  burst_e      burst,
   output logic [31:0] next_addr
);

   logic [31:0] mask_s;
   logic [31:0] incr_s;

   // Wrap keeps the bits above the container and rolls the bits inside it.
   always_comb begin
      mask_s = (({24'd0, len} + 32'd1) << 2'd2) - 32'd1;
      incr_s = addr + 32'd4;
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_INCR:  next_addr = incr_s;
         BURST_WRAP:  next_addr = (addr & ~mask_s) | (incr_s & mask_s);
         default:     next_addr = addr;
      endcase
   end

endmodule

// File: rtl/ysyx_23060203_axi_rd_sram.sv
// AXI4 read-only responder in front of a word-addressed synchronous SRAM,
// with a preload write port for boot/simulation.
module ysyx_23060203_axi_rd_sram
   import ysyx_23060203_axi_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
   parameter int          DEPTH_W   = 12,
   parameter int          LAT       = 2,
   parameter int          ID_W      = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               arvalid,
   output logic               arready,
   input  logic [31:0]        araddr,
   input  logic [ID_W-1:0]    arid,
   input  logic [7:0]         arlen,
   input  logic [2:0]         arsize,
   input  logic [1:0]         arburst,
   output logic               rvalid,
   input  logic               rready,
   output logic [31:0]        rdata,
   output logic [1:0]         rresp,
   output logic               rlast,
   output logic [ID_W-1:0]    rid,
   input  logic               init_wen,
   input  logic [DEPTH_W-1:0] init_addr,
   input  logic [31:0]        init_data
);

   localparam int NWORDS = 2 ** DEPTH_W;

   logic [31:0]     mem [NWORDS];

   state_t          state_q, state_d;
   logic [31:0]     addr_q, addr_d;
   logic [ID_W-1:0] id_q, id_d;
   logic [7:0]      len_q, len_d;
   burst_e          burst_q, burst_d;
   logic            slverr_q, slverr_d;
   logic [7:0]      beat_cnt_q, beat_cnt_d;
   logic [7:0]      lat_cnt_q, lat_cnt_d;

   logic            arready_q, rvalid_q, rlast_q;
   logic [31:0]     rdata_q;
   resp_e           rresp_q;
   logic [ID_W-1:0] rid_q;

   logic            ar_hs_s;
   logic            load_s;
   logic [31:0]     rd_addr_s;
   logic            rd_slverr_s;
   logic [31:0]     rd_off_s;
   logic [29:0]     rd_word_s;
   logic            rd_decerr_s;
   logic [31:0]     next_addr_s;

   assign ar_hs_s = arvalid && arready_q;

   ysyx_23060203_axi_burst_addr u_burst_addr (
      .addr      (addr_q),
      .len       (len_q),
      .burst     (burst_q),
      .next_addr (next_addr_s)
   );

   // Decode of the beat being fetched; low address bits never select data.
   always_comb begin
      rd_off_s    = rd_addr_s - ADDR_BASE;
      rd_word_s   = 30'(rd_off_s >> 2'd2);
      rd_decerr_s = (rd_addr_s < ADDR_BASE) ||
                    (rd_word_s[29:DEPTH_W] != {(30 - DEPTH_W){1'b0}});
   end

   // Next state; load_s marks the edge that fetches the next beat from SRAM.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      id_d        = id_q;
      len_d       = len_q;
      burst_d     = burst_q;
      slverr_d    = slverr_q;
      beat_cnt_d  = beat_cnt_q;
      lat_cnt_d   = lat_cnt_q;
      load_s      = 1'b0;
      rd_addr_s   = addr_q;
      rd_slverr_s = slverr_q;
      case (state_q)
         ST_IDLE: begin
            if (ar_hs_s) begin
               addr_d     = araddr;
               id_d       = arid;
               len_d      = arlen;
               burst_d    = burst_e'(arburst);
               slverr_d   = burst_slverr(arsize, burst_e'(arburst), arlen);
               beat_cnt_d = arlen;
               if (LAT == 0) begin
                  state_d     = ST_BURST;
                  load_s      = 1'b1;
                  rd_addr_s   = araddr;
                  rd_slverr_s = slverr_d;
               end else begin
                  state_d   = ST_WAIT;
                  lat_cnt_d = 8'(LAT - 1);
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (lat_cnt_q == 8'd0) begin
               state_d = ST_BURST;
               load_s  = 1'b1;
            end else begin
               lat_cnt_d = lat_cnt_q - 8'd1;
            end
         end
         ST_BURST: begin
            if (rvalid_q && rready) begin
               if (beat_cnt_q == 8'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  addr_d     = next_addr_s;
                  beat_cnt_d = beat_cnt_q - 8'd1;
                  load_s     = 1'b1;
                  rd_addr_s  = next_addr_s;
               end
            end else begin
               state_d = ST_BURST;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control state and latched request.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         addr_q     <= 32'd0;
         id_q       <= {ID_W{1'b0}};
         len_q      <= 8'd0;
         burst_q    <= BURST_FIXED;
         slverr_q   <= 1'b0;
         beat_cnt_q <= 8'd0;
         lat_cnt_q  <= 8'd0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         id_q       <= id_d;
         len_q      <= len_d;
         burst_q    <= burst_d;
         slverr_q   <= slverr_d;
         beat_cnt_q <= beat_cnt_d;
         lat_cnt_q  <= lat_cnt_d;
      end
   end

   // Registered R/AR outputs; beat payload only changes on load_s, so it holds during stalls.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rdata_q   <= 32'd0;
         rresp_q   <= RESP_OKAY;
         rid_q     <= {ID_W{1'b0}};
      end else begin
         arready_q <= (state_d == ST_IDLE);
         rvalid_q  <= (state_d == ST_BURST);
         rlast_q   <= (state_d == ST_BURST) && (beat_cnt_d == 8'd0);
         if (load_s) begin
            rid_q <= id_d;
            if (rd_slverr_s) begin
               rdata_q <= 32'd0;
               rresp_q <= RESP_SLVERR;
            end else if (rd_decerr_s) begin
               rdata_q <= 32'd0;
               rresp_q <= RESP_DECERR;
            end else begin
               rdata_q <= mem[rd_word_s[DEPTH_W-1:0]];
               rresp_q <= RESP_OKAY;
            end
         end else begin
            rid_q   <= rid_q;
            rdata_q <= rdata_q;
            rresp_q <= rresp_q;
         end
      end
   end

   // Preload port; contents are deliberately not reset.
   always_ff @(posedge clock) begin
      if (init_wen) begin
         mem[init_addr] <= init_data;
      end
   end

   assign arready = arready_q;
   assign rvalid  = rvalid_q;
   assign rlast   = rlast_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;
   assign rid     = rid_q;

endmodule

// File: tb/tb_ysyx_23060203_axi_rd_sram.sv
// Randomised self-checking bench for the AXI read SRAM responder.
module tb_ysyx_23060203_axi_rd_sram;

   localparam int          LAT     = 2;
   localparam int          ID_W    = 4;
   localparam int          DEPTH_W = 12;
   localparam int          NW      = 4096;
   localparam logic [31:0] BASE    = 32'h8000_0000;

   logic               clock;
   logic               reset;
   logic               arvalid;
   logic               arready;
   logic [31:0]        araddr;
   logic [ID_W-1:0]    arid;
   logic [7:0]         arlen;
   logic [2:0]         arsize;
   logic [1:0]         arburst;
   logic               rvalid;
   logic               rready;
   logic [31:0]        rdata;
   logic [1:0]         rresp;
   logic               rlast;
   logic [ID_W-1:0]    rid;
   logic               init_wen;
   logic [DEPTH_W-1:0] init_addr;
   logic [31:0]        init_data;

   int checks;
   int errors;

   logic [31:0] model_mem [NW];
   logic [31:0] exp_d [256];
   logic [1:0]  exp_r [256];

   ysyx_23060203_axi_rd_sram #(
      .ADDR_BASE (BASE),
      .DEPTH_W   (DEPTH_W),
      .LAT       (LAT),
      .ID_W      (ID_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .arvalid   (arvalid),
      .arready   (arready),
      .araddr    (araddr),
      .arid      (arid),
      .arlen     (arlen),
      .arsize    (arsize),
      .arburst   (arburst),
      .rvalid    (rvalid),
      .rready    (rready),
      .rdata     (rdata),
      .rresp     (rresp),
      .rlast     (rlast),
      .rid       (rid),
      .init_wen  (init_wen),
      .init_addr (init_addr),
      .init_data (init_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Byte address of beat i of a burst, from the AXI burst definitions.
   function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                             input logic [1:0] burst, input int i);
      logic [31:0] size;
      logic [31:0] lower;
      if (burst == 2'b01) return start + 32'(4 * i);
      if (burst == 2'b10) begin
         size  = 32'((len + 1) * 4);
         lower = start - (start % size);
         return lower + (((start - lower) + 32'(4 * i)) % size);
      end
      return start;
   endfunction

   function automatic logic is_slverr(input logic [2:0] size, input logic [1:0] burst, input int len);
      if (size != 3'b010) return 1'b1;
      if (burst == 2'b11) return 1'b1;
      if (burst == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic expect_beat(input logic [31:0] a, input logic slv,
                              output logic [31:0] d, output logic [1:0] r);
      logic [31:0] w;
      w = (a - BASE) >> 2;
      if (slv) begin
         d = 32'd0; r = 2'b10;
      end else if (a < BASE || w >= 32'(NW)) begin
         d = 32'd0; r = 2'b11;
      end else begin
         d = model_mem[w]; r = 2'b00;
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] data);
      init_wen  = 1'b1;
      init_addr = DEPTH_W'(idx);
      init_data = data;
      @(posedge clock); #1;
      init_wen = 1'b0;
      model_mem[idx] = data;
   endtask

   task automatic send_ar(input logic [31:0] a, input logic [ID_W-1:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input string name);
      int n;
      n = 0;
      while (arready !== 1'b1 && n < 20) begin
         @(posedge clock); #1; n++;
      end
      checks++;
      if (arready !== 1'b1) begin
         errors++;
         $display("FAIL %s arready: got %b expected 1", name, arready);
      end
      arvalid = 1'b1; araddr = a; arid = id; arlen = len; arsize = size; arburst = burst;
      @(posedge clock); #1;
      arvalid = 1'b0;
      araddr  = $urandom; arid = ID_W'($urandom); arlen = 8'($urandom);
      arsize  = 3'($urandom); arburst = 2'($urandom);
   endtask

   task automatic wait_first_beat(input string name);
      int n;
      n = 1;
      while (rvalid !== 1'b1 && n < LAT + 20) begin
         @(posedge clock); #1; n++;
      end
      checks++;
      if (n != LAT + 1) begin
         errors++;
         $display("FAIL %s latency: got %0d cycles expected %0d", name, n, LAT + 1);
      end
   endtask

   // rmode: 0 rready high, 1 toggling, 2 random. Optional preload collides with beat wr_beat's acceptance.
   task automatic run_burst(input logic [31:0] a, input logic [ID_W-1:0] id, input int len,
                            input logic [2:0] size, input logic [1:0] burst, input int rmode,
                            input string name, input int wr_beat = -1, input int wr_idx = 0,
                            input logic [31:0] wr_data = 32'd0, input logic junk_ar = 1'b0);
      logic slv;
      int   i;
      int   guard;
      slv = is_slverr(size, burst, len);
      for (int k = 0; k <= len; k++) expect_beat(beat_addr(a, len, burst, k), slv, exp_d[k], exp_r[k]);
      send_ar(a, id, 8'(len), size, burst, name);
      if (junk_ar) arvalid = 1'b1;
      wait_first_beat(name);
      i = 0; guard = 0;
      while (i <= len && guard < 2000) begin
         checks++;
         if ({rvalid, rdata, rresp, rid, rlast} !== {1'b1, exp_d[i], exp_r[i], id, (i == len)}) begin
            errors++;
            $display("FAIL %s beat %0d: got v=%b d=%h r=%b id=%h last=%b expected v=1 d=%h r=%b id=%h last=%b",
                     name, i, rvalid, rdata, rresp, rid, rlast, exp_d[i], exp_r[i], id, (i == len));
         end
         case (rmode)
            0:       rready = 1'b1;
            1:       rready = (guard % 2 == 0);
            default: rready = 1'($urandom);
         endcase
         if (i == wr_beat) begin
            rready = 1'b1; init_wen = 1'b1;
            init_addr = DEPTH_W'(wr_idx); init_data = wr_data;
         end
         @(posedge clock); #1;
         if (init_wen) begin
            init_wen = 1'b0;
            model_mem[wr_idx] = wr_data;
            for (int k = i + 2; k <= len; k++) expect_beat(beat_addr(a, len, burst, k), slv, exp_d[k], exp_r[k]);
         end
         if (rready) i++;
         guard++;
      end
      rready  = 1'b0;
      arvalid = 1'b0;
      checks++;
      if (rvalid !== 1'b0 || arready !== 1'b1) begin
         errors++;
         $display("FAIL %s end: got rvalid=%b arready=%b expected 0/1", name, rvalid, arready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; arvalid = 1'b0; rready = 1'b0; init_wen = 1'b0;
      araddr = 32'd0; arid = '0; arlen = 8'd0; arsize = 3'b010; arburst = 2'b01;
      init_addr = '0; init_data = 32'd0;
      #2 reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({arready, rvalid, rlast, rdata, rresp, rid} !== '0) begin
         errors++;
         $display("FAIL reset_state: got ar=%b v=%b l=%b d=%h r=%b id=%h expected all 0",
                  arready, rvalid, rlast, rdata, rresp, rid);
      end
      reset = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (arready !== 1'b1 || rvalid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: got arready=%b rvalid=%b expected 1/0", arready, rvalid);
      end
   endtask

   task automatic test_preload();
      for (int w = 0; w < NW; w++) preload(w, $urandom);
      preload(4, 32'hA4); preload(5, 32'hA5); preload(6, 32'hA6); preload(7, 32'hA7);
   endtask

   task automatic test_bursts();
      run_burst(32'h8000_0014, 4'd2, 3, 3'b010, 2'b10, 0, "wrap4");
      run_burst(32'h8000_0000, 4'd1, 7, 3'b010, 2'b01, 1, "incr8_stall");
      run_burst(32'h8000_0008, 4'd3, 2, 3'b010, 2'b00, 0, "fixed3");
      run_burst(32'h8000_0028, 4'd5, 3, 3'b010, 2'b00, 0, "preload_collide", 0, 10, 32'hDEAD_BEEF);
      run_burst(32'h8000_0006, 4'd6, 7, 3'b010, 2'b10, 2, "wrap8_unaligned");
   endtask

   task automatic test_decerr();
      run_burst(32'h8000_3FFC, 4'd7, 1, 3'b010, 2'b01, 0, "top_edge");
      run_burst(32'h7FFF_FFF8, 4'd8, 3, 3'b010, 2'b01, 0, "below_base");
      run_burst(32'hFFFF_FFFC, 4'd9, 1, 3'b010, 2'b01, 0, "addr_wrap32");
   endtask

   task automatic test_slverr();
      run_burst(32'h8000_0010, 4'hA, 1, 3'b001, 2'b01, 0, "bad_size");
      run_burst(32'h8000_0010, 4'hB, 2, 3'b010, 2'b10, 1, "bad_wrap_len");
      run_burst(32'h7000_0000, 4'hC, 0, 3'b010, 2'b11, 0, "rsvd_burst");
   endtask

   task automatic test_reset_mid_burst();
      send_ar(BASE, 4'hE, 8'd7, 3'b010, 2'b01, "mid_reset");
      wait_first_beat("mid_reset");
      rready = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if ({rvalid, rdata, rlast} !== {1'b1, model_mem[2], 1'b0}) begin
         errors++;
         $display("FAIL mid_reset beat2: got v=%b d=%h l=%b expected 1 %h 0", rvalid, rdata, rlast, model_mem[2]);
      end
      reset = 1'b0;
      #1;
      checks++;
      if ({arready, rvalid, rlast, rdata, rresp, rid} !== '0) begin
         errors++;
         $display("FAIL mid_reset async: got ar=%b v=%b l=%b d=%h expected all 0", arready, rvalid, rlast, rdata);
      end
      repeat (2) @(posedge clock);
      #1;
      rready = 1'b0;
      reset  = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (arready !== 1'b1 || rvalid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset release: got arready=%b rvalid=%b expected 1/0", arready, rvalid);
      end
      run_burst(32'h8000_0100, 4'h3, 3, 3'b010, 2'b01, 0, "after_reset");
   endtask

   task automatic test_random();
      logic [31:0] a;
      logic [1:0]  burst;
      logic [2:0]  size;
      int          len;
      int          sel;
      for (int t = 0; t < 30; t++) begin
         sel   = $urandom_range(0, 9);
         burst = (sel == 9) ? 2'b11 : 2'($urandom_range(0, 2));
         size  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b010;
         if (burst == 2'b10) len = (2 << $urandom_range(0, 3)) - 1;
         else len = $urandom_range(0, 15);
         case ($urandom_range(0, 7))
            0:       a = BASE - 32'(4 * $urandom_range(1, 4));
            1:       a = BASE + 32'(4 * (NW - $urandom_range(1, 4)));
            default: a = BASE + 32'(4 * $urandom_range(0, NW - 1)) + 32'($urandom_range(0, 3));
         endcase
         run_burst(a, ID_W'($urandom), len, size, burst, 2, "random", -1, 0, 32'd0, 1'($urandom));
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_preload();
      test_bursts();
      test_decerr();
      test_slverr();
      test_reset_mid_burst();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
